oka_overlap_accum: RTL

Parametrised sequential successor to the 5-bit overlap recombiner in the overlap-free Karatsuba (OKA) multiplier datapath. It collects four GF(2) sub-products P1..P4, each W = N-1 bits wide, over a shared valid/ready input channel, in any order. It XOR-interleaves them into one 2N-1 bit overlap word and presents the result on a valid/ready output channel. It sits between the sub-multiplier stage and the next recombination level, so one narrow bus can feed the recombiner serially.

---
 rtl/oka_overlap_accum.sv | 113 +++++++++++
 1 files changed

// File: rtl/oka_overlap_accum.sv
// Serial overlap recombiner for the OKA multiplier: gathers P1..P4 in any order and emits the 2N-1 bit overlap word.
// Optional macro OVL_DUP_CNT_EN adds an 8-bit saturating duplicate-part counter output (dup_cnt).
module oka_overlap_accum #(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_sel,
    input  logic [N-2:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] out_data,
    output logic           dup_err
`ifdef OVL_DUP_CNT_EN
    ,
    output logic [7:0]     dup_cnt
`endif
);

    typedef enum logic {
        COLLECT,
        OUTPUT
    } state_t;

    state_t           state;
    logic [3:0]       mask;
    logic [2*N-2:0]   acc;
    logic [2*N-2:0]   part_bits;
    logic [2*N-2:0]   acc_next;
    logic [3:0]       sel_bit;
    logic [3:0]       mask_next;

    // P1 lands on even bits, P2/P3 share the odd bits, P4 is P1 shifted up by two.
    always_comb begin
        part_bits = '0;
        for (int i = 0; i < N - 1; i++) begin
            case (in_sel)
                2'd0:    part_bits[2*i]     = in_data[i];
                2'd1,
                2'd2:    part_bits[2*i + 1] = in_data[i];
                default: part_bits[2*i + 2] = in_data[i];
            endcase
        end
    end

    assign acc_next  = acc ^ part_bits;
    assign sel_bit   = 4'b0001 << in_sel;
    assign mask_next = mask | sel_bit;
    assign in_ready  = (state == COLLECT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= COLLECT;
            mask      <= 4'b0000;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            dup_err   <= 1'b0;
        end else begin
            dup_err <= 1'b0;
            if (clear) begin
                state     <= COLLECT;
                mask      <= 4'b0000;
                acc       <= '0;
                out_valid <= 1'b0;
                out_data  <= '0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (in_valid) begin
                            if (mask[in_sel]) begin
                                dup_err <= 1'b1;
                            end else begin
                                acc  <= acc_next;
                                mask <= mask_next;
                                if (mask_next == 4'b1111) begin
                                    state     <= OUTPUT;
                                    out_valid <= 1'b1;
                                    out_data  <= acc_next;
                                end
                            end
                        end
                    end
                    OUTPUT: begin
                        if (out_ready) begin
                            state     <= COLLECT;
                            mask      <= 4'b0000;
                            acc       <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                        end
                    end
                    default: state <= COLLECT;
                endcase
            end
        end
    end

`ifdef OVL_DUP_CNT_EN
    // Counts registered dup_err pulses; survives clear so software can read it after an abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dup_cnt <= 8'h00;
        end else if (dup_err && (dup_cnt != 8'hFF)) begin
            dup_cnt <= dup_cnt + 8'h01;
        end
    end
`endif

endmodule
